// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared FSM states, Booth digit codes and iteration helpers for booth_seq_mult
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth digit codes as {neg, one, two}
  localparam logic [2:0] DIG_ZERO = 3'b000;
  localparam logic [2:0] DIG_P1   = 3'b010;
  localparam logic [2:0] DIG_P2   = 3'b001;
  localparam logic [2:0] DIG_M1   = 3'b110;
  localparam logic [2:0] DIG_M2   = 3'b101;

  // One radix-4 digit per cycle over the (WIDTH+2)-bit extended multiplier
  function automatic int num_iters(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int iter_width(input int width);
    return (num_iters(width) > 1) ? $clog2(num_iters(width)) : 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// rtl/booth_r4_encoder.sv - radix-4 Booth window {b[2i+1],b[2i],b[2i-1]} to {neg, one, two}
module booth_r4_encoder
  import vm_pkg::*;
(
  input  logic [2:0] window,
  output logic       neg,
  output logic       one,
  output logic       two
);

  logic [2:0] dig;

  // Map the 3-bit window onto a digit in {-2,-1,0,+1,+2}
  always_comb begin
    dig = DIG_ZERO;
    case (window)
      3'b000, 3'b111: dig = DIG_ZERO;
      3'b001, 3'b010: dig = DIG_P1;
      3'b011:         dig = DIG_P2;
      3'b100:         dig = DIG_M2;
      3'b101, 3'b110: dig = DIG_M1;
      default:        dig = DIG_ZERO;
    endcase
    {neg, one, two} = dig;
  end

endmodule

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - iterative radix-4 Booth multiplier with valid/ready handshake; optional MAC via VM_MAC_EN
module booth_seq_mult
  import vm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
`ifdef VM_MAC_EN
  input  logic               acc_clear,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int AW = 2 * WIDTH + 4;
  localparam int BW = WIDTH + 3;
  localparam int N  = num_iters(WIDTH);
  localparam int IW = iter_width(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t            state, state_next;
  logic [IW-1:0]     iter;
  logic [AW-1:0]     mcand;
  logic [AW-1:0]     acc;
  logic [BW-1:0]     mplier;
  logic              neg, one, two;
  logic [AW-1:0]     mag, pp, sum;
  logic [2*WIDTH-1:0] product, final_val;
  logic              a_ext, b_ext;

`ifdef VM_MAC_EN
  logic [2*WIDTH-1:0] mac_acc;
  logic               clr_q;
`endif

  // The low three multiplier bits always hold the current Booth window
  booth_r4_encoder u_enc (
    .window (mplier[2:0]),
    .neg    (neg),
    .one    (one),
    .two    (two)
  );

  // Partial product for this digit and the running sum
  always_comb begin
    a_ext     = signed_mode & a[WIDTH-1];
    b_ext     = signed_mode & b[WIDTH-1];
    mag       = '0;
    if (two)
      mag = {mcand[AW-2:0], 1'b0};
    else if (one)
      mag = mcand;
    pp        = neg ? (~mag + AW'(1)) : mag;
    sum       = acc + pp;
    product   = sum[2*WIDTH-1:0];
`ifdef VM_MAC_EN
    final_val = (clr_q ? '0 : mac_acc) + product;
`else
    final_val = product;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (iter == LAST)
          state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, one Booth digit per BUSY cycle, result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter   <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      result <= '0;
`ifdef VM_MAC_EN
      mac_acc <= '0;
      clr_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{(AW-WIDTH){a_ext}}, a};
            mplier <= {{2{b_ext}}, b, 1'b0};
            acc    <= '0;
            iter   <= '0;
`ifdef VM_MAC_EN
            clr_q  <= acc_clear;
`endif
          end
        end
        BUSY: begin
          acc    <= sum;
          mcand  <= {mcand[AW-3:0], 2'b00};
          mplier <= {2'b00, mplier[BW-1:2]};
          iter   <= iter + 1'b1;
          if (iter == LAST)
            result <= final_val;
        end
        DONE: begin
`ifdef VM_MAC_EN
          if (out_ready)
            mac_acc <= result;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - directed self-checking bench for booth_seq_mult (WIDTH=32 and WIDTH=8)
module tb_booth_seq_mult;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        iv32 = 1'b0, or32 = 1'b0, sm32 = 1'b0, clr32 = 1'b1;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ir32, ov32, busy32;
  logic [63:0] res32;

  logic        iv8 = 1'b0, or8 = 1'b0, sm8 = 1'b0, clr8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8, busy8;
  logic [15:0] res8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  booth_seq_mult #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .signed_mode(sm32),
`ifdef VM_MAC_EN
    .acc_clear(clr32),
`endif
    .out_valid(ov32), .out_ready(or32), .result(res32), .busy(busy32)
  );

  booth_seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .signed_mode(sm8),
`ifdef VM_MAC_EN
    .acc_clear(clr8),
`endif
    .out_valid(ov8), .out_ready(or8), .result(res8), .busy(busy8)
  );

  task automatic start32(input logic [31:0] ia, input logic [31:0] ib, input logic sm, input logic clr);
    int guard = 0;
    while (!ir32 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    a32 = ia; b32 = ib; sm32 = sm; clr32 = clr; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom; sm32 = ~sm; clr32 = ~clr;
  endtask

  task automatic wait32(output logic [63:0] res, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ov32) begin
        lat = k;
        break;
      end
    end
    res = res32;
  endtask

  task automatic op32(input logic [31:0] ia, input logic [31:0] ib, input logic sm, input logic clr,
                      output logic [63:0] res, output int lat);
    start32(ia, ib, sm, clr);
    wait32(res, lat);
  endtask

  task automatic handshake32();
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic sm,
                     output logic [15:0] res, output int lat);
    int guard = 0;
    while (!ir8 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    a8 = ia; b8 = ib; sm8 = sm; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ov8) begin
        lat = k;
        break;
      end
    end
    res = res8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (ir32 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", ir32); end
    tests++; if (ov32 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", ov32); end
    tests++; if (busy32 !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy32); end
    tests++; if (res32 !== 64'h0) begin fails++; $display("FAIL reset_result got=%h want=0", res32); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic        vs [6];
    logic [63:0] ve [6];
    logic [63:0] r;
    int          lat;
    va[0] = 32'd50;        vb[0] = -32'sd40;      vs[0] = 1'b1; ve[0] = 64'hFFFF_FFFF_FFFF_F830;
    va[1] = -32'sd999;     vb[1] = 32'd999;       vs[1] = 1'b1; ve[1] = -64'sd998001;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; vs[2] = 1'b0; ve[2] = 64'hFFFF_FFFE_0000_0001;
    va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000; vs[3] = 1'b1; ve[3] = 64'h4000_0000_0000_0000;
    va[4] = 32'h8000_0000; vb[4] = 32'h0;         vs[4] = 1'b1; ve[4] = 64'h0;
    va[5] = 32'h8000_0000; vb[5] = 32'h1;         vs[5] = 1'b1; ve[5] = 64'hFFFF_FFFF_8000_0000;
    for (int i = 0; i < 6; i++) begin
      op32(va[i], vb[i], vs[i], 1'b1, r, lat);
      tests++; if (r !== ve[i]) begin fails++; $display("FAIL basic_result[%0d] got=%h want=%h", i, r, ve[i]); end
      tests++; if (lat !== 17) begin fails++; $display("FAIL basic_latency[%0d] got=%0d want=17", i, lat); end
      handshake32();
      tests++; if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
        fails++; $display("FAIL basic_after_hs[%0d] got ov=%b ir=%b want ov=0 ir=1", i, ov32, ir32);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    int          lat;
    op32(32'd7, 32'd6, 1'b0, 1'b1, r, lat);
    tests++; if (r !== 64'd42 || lat !== 17) begin
      fails++; $display("FAIL stall_first got=%h lat=%0d want=2a lat=17", r, lat);
    end
    for (int c = 0; c < 5; c++) begin
      iv32 = 1'b1; a32 = 32'd1000 + c; b32 = 32'd3;
      @(posedge clk); #1;
      tests++; if (ov32 !== 1'b1 || res32 !== 64'd42 || ir32 !== 1'b0) begin
        fails++; $display("FAIL stall_hold[%0d] got ov=%b res=%h ir=%b want ov=1 res=2a ir=0", c, ov32, res32, ir32);
      end
    end
    iv32 = 1'b0;
    handshake32();
    tests++; if (ov32 !== 1'b0 || res32 !== 64'd42 || ir32 !== 1'b1) begin
      fails++; $display("FAIL stall_release got ov=%b res=%h ir=%b want ov=0 res=2a ir=1", ov32, res32, ir32);
    end
    start32(32'd3, 32'd5, 1'b0, 1'b1);
    tests++; if (busy32 !== 1'b1 || ir32 !== 1'b0) begin
      fails++; $display("FAIL b2b_accept got busy=%b ir=%b want busy=1 ir=0", busy32, ir32);
    end
    wait32(r, lat);
    tests++; if (r !== 64'd15 || lat !== 17) begin
      fails++; $display("FAIL b2b_result got=%h lat=%0d want=f lat=17", r, lat);
    end
    handshake32();
  endtask

  task automatic test_reset_mid();
    logic [63:0] r;
    int          lat;
    start32(32'd12345, 32'd678, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
    end
    tests++; if (busy32 !== 1'b1 || ov32 !== 1'b0) begin
      fails++; $display("FAIL midreset_pre got busy=%b ov=%b want busy=1 ov=0", busy32, ov32);
    end
    #2 reset = 1'b0;
    #1;
    tests++; if (ov32 !== 1'b0 || busy32 !== 1'b0 || ir32 !== 1'b1 || res32 !== 64'h0) begin
      fails++; $display("FAIL midreset_state got ov=%b busy=%b ir=%b res=%h want 0 0 1 0", ov32, busy32, ir32, res32);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    op32(-32'sd90, 32'd70, 1'b1, 1'b1, r, lat);
    tests++; if (r !== -64'sd6300 || lat !== 17) begin
      fails++; $display("FAIL midreset_next got=%h lat=%0d want=%h lat=17", r, lat, -64'sd6300);
    end
    handshake32();
  endtask

`ifdef VM_MAC_EN
  task automatic test_mac();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vc [4];
    logic [63:0] ve [4];
    logic [63:0] r;
    int          lat;
    va[0] = 32'd10; vb[0] = 32'd10;  vc[0] = 1'b1; ve[0] = 64'd100;
    va[1] = 32'd3;  vb[1] = -32'sd4; vc[1] = 1'b0; ve[1] = 64'd88;
    va[2] = 32'd2;  vb[2] = 32'd2;   vc[2] = 1'b0; ve[2] = 64'd92;
    va[3] = 32'd5;  vb[3] = 32'd5;   vc[3] = 1'b1; ve[3] = 64'd25;
    for (int i = 0; i < 4; i++) begin
      op32(va[i], vb[i], 1'b1, vc[i], r, lat);
      tests++; if (r !== ve[i] || lat !== 17) begin
        fails++; $display("FAIL mac[%0d] got=%h lat=%0d want=%h lat=17", i, r, lat, ve[i]);
      end
      handshake32();
    end
  endtask
`endif

  task automatic test_width8();
    logic [7:0]  ta, tb_;
    logic        ts;
    logic [15:0] ea, eb, exp, r;
    int          lat;
    for (int i = 0; i < 20; i++) begin
      case (i)
        0:       begin ta = 8'h80; tb_ = 8'h80; ts = 1'b1; end
        1:       begin ta = 8'hFF; tb_ = 8'hFF; ts = 1'b0; end
        2:       begin ta = 8'hFF; tb_ = 8'hFF; ts = 1'b1; end
        3:       begin ta = 8'h7F; tb_ = 8'h80; ts = 1'b1; end
        default: begin ta = 8'($urandom); tb_ = 8'($urandom); ts = 1'($urandom); end
      endcase
      ea  = ts ? {{8{ta[7]}}, ta} : {8'h00, ta};
      eb  = ts ? {{8{tb_[7]}}, tb_} : {8'h00, tb_};
      exp = ea * eb;
      op8(ta, tb_, ts, r, lat);
      tests++; if (r !== exp || lat !== 5) begin
        fails++; $display("FAIL w8[%0d] a=%h b=%h s=%b got=%h lat=%0d want=%h lat=5", i, ta, tb_, ts, r, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
`ifdef VM_MAC_EN
    test_mac();
`endif
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
